// File: rtl/mem_access_unit.sv
// Memory access unit: IDLE/ACCESS/RESP sequencer with MAR/MDR registers and byte-lane steering.
// Define MEM_TIMEOUT_EN to build the ACCESS-state timeout counter (rsp_err); otherwise rsp_err is 0.
module mem_access_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BE_W - 1);

  if (DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("mem_access_unit: DATA_WIDTH must be 16 or 32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic [LANE_W-1:0]   lane;
  logic                is_write;
  logic                is_byte;
  logic                timeout_hit;
  logic [LANE_W-1:0]   lane_sel;

  function automatic logic [DATA_WIDTH-1:0] place_byte(input logic [7:0] b,
                                                       input logic [LANE_W-1:0] l);
    return DATA_WIDTH'(b) << {l, 3'b000};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract_byte(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [LANE_W-1:0] l);
    logic [DATA_WIDTH-1:0] s;
    s = w >> {l, 3'b000};
    return {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
  endfunction

  assign lane_sel    = req_addr[LANE_W-1:0];
  assign req_ready   = (state == IDLE);
  assign mem_address = mar;
  assign mem_wdata   = mdr;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // The edge that would take the count to TIMEOUT is the abort edge, giving TIMEOUT strobe cycles.
  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid)
        to_cnt <= '0;
      else if (state == ACCESS && !mem_resp)
        to_cnt <= to_cnt + 1'b1;
      err_q <= (state == ACCESS) && timeout_hit && !mem_resp;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mar             <= '0;
      mdr             <= '0;
      lane            <= '0;
      is_write        <= 1'b0;
      is_byte         <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      rsp_valid       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            mar       <= req_addr & ADDR_MASK;
            lane      <= lane_sel;
            is_write  <= req_write;
            is_byte   <= req_byte;
            mem_read  <= !req_write;
            mem_write <= req_write;
            if (req_write && req_byte) begin
              mdr             <= place_byte(req_wdata[7:0], lane_sel);
              mem_byte_enable <= BE_W'(1) << lane_sel;
            end else begin
              if (req_write)
                mdr <= req_wdata;
              mem_byte_enable <= '1;
            end
          end
        end
        ACCESS: begin
          // mem_resp wins over a timeout on the same edge.
          if (mem_resp || timeout_hit) begin
            state           <= RESP;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            rsp_valid       <= 1'b1;
            if (mem_resp && !is_write)
              mdr <= mem_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !is_write && !rsp_err)
      rsp_rdata = is_byte ? extract_byte(mdr, lane) : mdr;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 16-bit instance (TIMEOUT=4) for most cases, 32-bit instance for lane steering.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_valid, req_write, req_byte, mem_resp;
  logic [15:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
  logic [15:0] rsp_rdata, mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;

  logic        w_req_valid, w_req_write, w_req_byte, w_mem_resp;
  logic [15:0] w_req_addr;
  logic [31:0] w_req_wdata, w_mem_rdata;
  logic        w_req_ready, w_rsp_valid, w_rsp_err, w_mem_read, w_mem_write;
  logic [31:0] w_rsp_rdata, w_mem_wdata;
  logic [15:0] w_mem_address;
  logic [3:0]  w_mem_byte_enable;

  mem_access_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(4)) dut16 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write), .req_byte(w_req_byte),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err),
    .mem_address(w_mem_address), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .mem_byte_enable(w_mem_byte_enable), .mem_wdata(w_mem_wdata),
    .mem_rdata(w_mem_rdata), .mem_resp(w_mem_resp)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic        write;
    logic        byte_acc;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int strobes;
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_write = v.write; req_byte = v.byte_acc;
    req_addr = v.addr; req_wdata = v.wdata; mem_rdata = 16'hDEAD;
    @(negedge clk);
    req_valid = 0;
    chk("mar", mem_address, v.exp_addr);
    chk("byte_enable", mem_byte_enable, v.exp_be);
    if (v.write) chk("mdr", mem_wdata, v.exp_wdata);
    chk("ready_busy", req_ready, 0);
    strobes = 0;
    for (int i = 1; i <= v.delay; i++) begin
      if (mem_read == !v.write && mem_write == v.write && !rsp_valid) strobes++;
      if (i == v.delay) begin mem_resp = 1; mem_rdata = v.rdata; end
      @(negedge clk);
    end
    mem_resp = 0;
    chk("strobe_cycles", strobes, v.delay);
    chk("strobes_drop", {mem_read, mem_write}, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rsp);
    chk("rsp_err", rsp_err, 0);
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, rsps, cnt;
    reset = 1;
    req_valid = 0; req_write = 0; req_byte = 0; req_addr = 0; req_wdata = 0;
    mem_rdata = 0; mem_resp = 0;
    w_req_valid = 0; w_req_write = 0; w_req_byte = 0; w_req_addr = 0; w_req_wdata = 0;
    w_mem_rdata = 0; w_mem_resp = 0;

    // write, byte, addr, wdata, rdata, delay, exp_addr, exp_be, exp_wdata, exp_rsp
    vecs[0] = '{1'b0, 1'b0, 16'h1235, 16'h0000, 16'hBEEF, 3, 16'h1234, 2'b11, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0041, 16'h0000, 16'hA55A, 1, 16'h0040, 2'b11, 16'h0000, 16'h00A5};
    vecs[2] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hA55A, 2, 16'h0040, 2'b11, 16'h0000, 16'h005A};
    vecs[3] = '{1'b1, 1'b0, 16'h2000, 16'h1357, 16'h9999, 2, 16'h2000, 2'b11, 16'h1357, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h3001, 16'h12CD, 16'h9999, 1, 16'h3000, 2'b10, 16'hCD00, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 16'h3000, 16'hFF34, 16'h9999, 4, 16'h3000, 2'b01, 16'h0034, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 1, 16'hFFFE, 2'b11, 16'h0000, 16'h8001};

    @(negedge clk); @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_be", mem_byte_enable, 0);
    chk("rst_mar", mem_address, 0);
    chk("rst_mdr", mem_wdata, 0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Spurious mem_resp while idle.
    mem_resp = 1;
    @(negedge clk);
    mem_resp = 0;
    chk("spur_rsp_valid", rsp_valid, 0);
    chk("spur_ready", req_ready, 1);
    chk("spur_mem_read", mem_read, 0);
    @(negedge clk);
    chk("spur_rsp_valid2", rsp_valid, 0);

    // req_valid and mem_resp held high: one accept per response, back-to-back.
    req_valid = 1; req_write = 0; req_byte = 0; req_addr = 16'h0010;
    mem_resp = 1; mem_rdata = 16'h4242;
    acc = 0; rsps = 0;
    for (int i = 0; i < 9; i++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    req_valid = 0; mem_resp = 0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_responses", rsps, 3);
    chk("b2b_ready_after", req_ready, 1);

    // Load with no mem_resp: timeout abort, or indefinite wait without the timeout build.
    req_valid = 1; req_write = 0; req_byte = 0; req_addr = 16'h0700; mem_rdata = 16'h7777;
    @(negedge clk);
    req_valid = 0;
    cnt = 0; rsps = 0;
    while (mem_read && cnt < 20) begin
      cnt++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    chk("hang_no_rsp", rsps, 0);
`ifdef MEM_TIMEOUT_EN
    chk("to_strobe_cycles", cnt, 4);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    chk("to_rsp_end", rsp_valid, 0);
`else
    chk("wait_cycles", cnt, 20);
    chk("wait_mem_read", mem_read, 1);
    mem_resp = 1; mem_rdata = 16'h0F0F;
    @(negedge clk);
    mem_resp = 0;
    chk("wait_rsp_valid", rsp_valid, 1);
    chk("wait_rsp_err", rsp_err, 0);
    chk("wait_rsp_rdata", rsp_rdata, 16'h0F0F);
    @(negedge clk);
`endif

    // 32-bit lane steering: byte store then byte load.
    w_req_valid = 1; w_req_write = 1; w_req_byte = 1; w_req_addr = 16'h0103; w_req_wdata = 32'h0000_12CD;
    @(negedge clk);
    w_req_valid = 0;
    chk("w_mar", w_mem_address, 16'h0100);
    chk("w_be", w_mem_byte_enable, 4'b1000);
    chk("w_mdr", w_mem_wdata, 32'hCD00_0000);
    chk("w_strobes", {w_mem_read, w_mem_write}, 2'b01);
    w_mem_resp = 1;
    @(negedge clk);
    w_mem_resp = 0;
    chk("w_st_rsp_valid", w_rsp_valid, 1);
    chk("w_st_rsp_rdata", w_rsp_rdata, 0);
    @(negedge clk);
    w_req_valid = 1; w_req_write = 0; w_req_byte = 1; w_req_addr = 16'h0102;
    @(negedge clk);
    w_req_valid = 0;
    chk("w_ld_be", w_mem_byte_enable, 4'b1111);
    chk("w_ld_mar", w_mem_address, 16'h0100);
    w_mem_resp = 1; w_mem_rdata = 32'h1122_3344;
    @(negedge clk);
    w_mem_resp = 0;
    chk("w_ld_rsp_valid", w_rsp_valid, 1);
    chk("w_ld_rsp_rdata", w_rsp_rdata, 32'h0000_0022);
    @(negedge clk);

    // Reset two cycles into a store.
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'h0500; req_wdata = 16'hAAAA;
    @(negedge clk);
    req_valid = 0;
    chk("rm_mem_write", mem_write, 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rm_write_drop", mem_write, 0);
    chk("rm_ready", req_ready, 1);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_mar", mem_address, 0);
    @(negedge clk);
    reset = 0;
    rsps = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    chk("rm_no_rsp", rsps, 0);
    chk("rm_ready_after", req_ready, 1);
    chk("rm_idle_strobes", {mem_read, mem_write}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, memory/datapath word width; legal values 16 or 32.
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 Parameter TIMEOUT, default 255, maximum ACCESS-state cycles before abort; legal range 1..65535; used only under MEM_TIMEOUT_EN.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  1  datapath access request.
REQ-007 Port req_ready  output  1  unit idle and able to accept a request.
REQ-008 Port req_write  input  1  1 = store, 0 = load.
REQ-009 Port req_byte  input  1  1 = byte access (LDB/STB), 0 = word access.
REQ-010 Port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 Port req_wdata  input  DATA_WIDTH  store data; for byte stores, bits [7:0] only.
REQ-012 Port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 Port rsp_rdata  output  DATA_WIDTH  load result.
REQ-014 Port rsp_err  output  1  access aborted by timeout; valid with rsp_valid.
REQ-015 Port mem_address  output  ADDR_WIDTH  registered (MAR) memory address.
REQ-016 Port mem_read, mem_write  output  1 each  memory strobes.
REQ-017 Port mem_byte_enable  output  DATA_WIDTH/8  write lane enables.
REQ-018 Port mem_wdata  output  DATA_WIDTH  registered (MDR) store data.
REQ-019 Port mem_rdata  input  DATA_WIDTH  memory read data.
REQ-020 Port mem_resp  input  1  memory completion, sampled only in ACCESS.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-022 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 On req_valid & req_ready: MAR <= req_addr with the low log2(DATA_WIDTH/8) bits cleared; state -> ACCESS.
REQ-024 On the same accept edge, for word stores: MDR <= req_wdata; byte_enable <= all ones.
REQ-025 On the same accept edge, for byte stores: req_wdata[7:0] is placed in the lane selected by the low address bits, other lanes are 0, and byte_enable is one-hot on that lane.
REQ-026 For loads, byte_enable SHALL be all ones; the latched lane index SHALL be retained for extraction.
REQ-027 In ACCESS, mem_read (load) or mem_write (store) SHALL be held at 1 every cycle until mem_resp; never both.
REQ-028 On mem_resp in ACCESS: for loads, MDR <= mem_rdata; state -> RESP; strobes drop on the next cycle.
REQ-029 In RESP, rsp_valid SHALL be 1 for exactly one cycle; state -> IDLE.
REQ-030 rsp_rdata SHALL be the MDR for word loads, the zero-extended selected byte for byte loads, and 0 for stores.
REQ-031 Latency: request accepted at edge N with mem_resp at edge N+k SHALL produce rsp_valid at cycle N+k+1; minimum 2 cycles accept-to-response.
REQ-032 mem_resp in IDLE or RESP SHALL be ignored; req_valid while req_ready=0 SHALL be ignored (not queued).
REQ-033 Back-to-back: a new request SHALL be acceptable in the cycle after rsp_valid.

Reset
REQ-034 reset SHALL asynchronously force IDLE, MAR=0, MDR=0, lane index=0, timeout counter=0.
REQ-035 While in reset: req_ready=1, rsp_valid=0, rsp_err=0, mem_read=0, mem_write=0, byte_enable=0.
REQ-036 Reset asserted mid-ACCESS SHALL drop strobes immediately with no rsp_valid; the aborted access is lost.

Configuration
REQ-037 Macro MEM_TIMEOUT_EN defined: a counter (width clog2(TIMEOUT+1)) clears on accept and increments each ACCESS cycle without mem_resp.
REQ-038 With MEM_TIMEOUT_EN, the counter reaching TIMEOUT SHALL drop strobes, go to RESP, and assert rsp_err=1 with rsp_rdata=0; mem_resp on that same edge wins (normal completion, rsp_err=0).
REQ-039 Macro undefined: no counter is built, ACCESS waits indefinitely, and rsp_err is tied 0.

Verification
REQ-040 Word load at addr 0x1235, DATA_WIDTH=16, mem_rdata=0xBEEF, mem_resp after 3 cycles -> mem_address=0x1234, mem_read high 3 cycles, rsp_valid one cycle later with rsp_rdata=0xBEEF.
REQ-041 Byte load at addr 0x0041, mem_rdata=0xA55A -> rsp_rdata=0x00A5; at addr 0x0040 -> 0x005A.
REQ-042 Byte store at addr 0x0103 with req_wdata=0x12CD, DATA_WIDTH=32 -> mem_wdata=0xCD000000, byte_enable=4'b1000, mem_address=0x0100.
REQ-043 req_valid held high during ACCESS plus a spurious mem_resp in IDLE -> exactly one accept per rsp_valid, and no response is generated by the spurious mem_resp.
REQ-044 reset pulsed 2 cycles into a store -> mem_write drops asynchronously, no rsp_valid, req_ready=1.
REQ-045 MEM_TIMEOUT_EN with TIMEOUT=4, mem_resp never asserted -> mem_read high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
